// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared scoreboard types and constants for the pipeline hazard unit
package pipe_pkg;

  // Widest register index any pipeline instance may use; narrower indices are zero-extended.
  localparam int SB_DST_W = 8;

  // Forwarding select value meaning "take the operand from the register file".
  localparam int FWD_SRC_RF = 0;

  // Nop instruction loaded by the stage registers on bubble/flush.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic                v;
    logic [SB_DST_W-1:0] dst;
    logic                load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{v: 1'b0, dst: '0, load: 1'b0};

endpackage

// File: rtl/pipe_hazard_unit_sb_match.sv
// rtl/pipe_hazard_unit_sb_match.sv - youngest-match priority encoder over the scoreboard
module sb_match
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int DEPTH    = 3,
  parameter int ZERO_REG = 0,
  parameter int FWD_W    = 2
) (
  input  logic                    use_op,
  input  logic [REG_AW-1:0]       src,
  input  logic [DEPTH-1:0]        v,
  input  logic [DEPTH*REG_AW-1:0] dst,
  output logic                    hit_young,
  output logic [FWD_W-1:0]        sel
);

  logic zero_src;
  logic hit;

  assign zero_src = (ZERO_REG != 0) && (src == '0);

  // Scan oldest to youngest so the youngest (lowest index) match is the last one written.
  always_comb begin
    sel       = FWD_W'(FWD_SRC_RF);
    hit_young = 1'b0;
    hit       = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hit = use_op && v[i] && (dst[i*REG_AW +: REG_AW] == src) && !zero_src;
      if (hit) begin
        sel = FWD_W'(i + 1);
      end
      if (i == 0) begin
        hit_young = hit;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - scoreboard-based forwarding, load-use stall and redirect flush control
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW       = 4,
  parameter int DEPTH        = 3,
  parameter int REDIRECT_STG = 1,
  parameter int ZERO_REG     = 0,
  parameter int CNT_W        = 16,
  parameter int FWD_W        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_srcA,
  input  logic              id_useA,
  input  logic [REG_AW-1:0] id_srcB,
  input  logic              id_useB,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wen,
  input  logic              id_load,
  input  logic              redirect,
  output logic              stall_f,
  output logic              stall_d,
  output logic              bubble_e,
  output logic              flush_d,
  output logic [FWD_W-1:0]  fwdA_sel,
  output logic [FWD_W-1:0]  fwdB_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  if (REDIRECT_STG < 0 || REDIRECT_STG >= DEPTH) begin : g_bad_redirect
    $error("pipe_hazard_unit: REDIRECT_STG must lie in [0, DEPTH)");
  end
  if (REG_AW > SB_DST_W || REG_AW < 1) begin : g_bad_reg_aw
    $error("pipe_hazard_unit: REG_AW out of range");
  end

  sb_entry_t                sb     [DEPTH];
  sb_entry_t                sb_nxt [DEPTH];
  logic [DEPTH-1:0]         sb_v;
  logic [DEPTH*REG_AW-1:0]  sb_dst;
  logic                     hit_a;
  logic                     hit_b;
  logic                     lu;
  logic                     stall_ev;
  logic                     unused_sb;

  always_comb begin
    sb_v      = '0;
    sb_dst    = '0;
    unused_sb = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sb_v[i]                   = sb[i].v;
      sb_dst[i*REG_AW +: REG_AW] = sb[i].dst[REG_AW-1:0];
      unused_sb                 = unused_sb ^ (^sb[i]);
    end
  end

  sb_match #(
    .REG_AW  (REG_AW),
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG),
    .FWD_W   (FWD_W)
  ) u_match_a (
    .use_op   (id_useA),
    .src      (id_srcA),
    .v        (sb_v),
    .dst      (sb_dst),
    .hit_young(hit_a),
    .sel      (fwdA_sel)
  );

  sb_match #(
    .REG_AW  (REG_AW),
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG),
    .FWD_W   (FWD_W)
  ) u_match_b (
    .use_op   (id_useB),
    .src      (id_srcB),
    .v        (sb_v),
    .dst      (sb_dst),
    .hit_young(hit_b),
    .sel      (fwdB_sel)
  );

  // Only a load sitting in execute cannot forward yet; older loads forward normally.
  assign lu       = id_valid && sb[0].load && (hit_a || hit_b);
  assign stall_ev = lu && !redirect;

  assign stall_f  = stall_ev;
  assign stall_d  = stall_ev;
  assign bubble_e = lu || redirect;
  assign flush_d  = redirect;

  // Redirect kills the wrong-path entries younger than the resolving stage before they shift.
  always_comb begin
    sb_nxt[0] = '{v:    id_valid && id_wen && !lu && !redirect,
                  dst:  SB_DST_W'(id_dst),
                  load: id_load};
    for (int i = 1; i < DEPTH; i++) begin
      sb_nxt[i] = sb[i-1];
      if (redirect && ((i - 1) < REDIRECT_STG)) begin
        sb_nxt[i].v = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb[i] <= SB_EMPTY;
      end
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hold) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb[i] <= sb_nxt[i];
      end
      if (stall_ev && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redirect && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - scoreboard bench for pipe_hazard_unit (two parameter sets)
module tb_pipe_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, hold, id_valid, id_useA, id_useB, id_wen, id_load, redirect;
  logic [3:0] id_srcA, id_srcB, id_dst;

  logic        sf [2], sd [2], be [2], fd [2];
  logic [1:0]  fa [2], fb [2];
  logic [15:0] sc0, fc0;
  logic [1:0]  sc1, fc1;

  pipe_hazard_unit #(
    .REG_AW(4), .DEPTH(3), .REDIRECT_STG(1), .ZERO_REG(0), .CNT_W(16)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid),
    .id_srcA(id_srcA), .id_useA(id_useA), .id_srcB(id_srcB), .id_useB(id_useB),
    .id_dst(id_dst), .id_wen(id_wen), .id_load(id_load), .redirect(redirect),
    .stall_f(sf[0]), .stall_d(sd[0]), .bubble_e(be[0]), .flush_d(fd[0]),
    .fwdA_sel(fa[0]), .fwdB_sel(fb[0]), .stall_cnt(sc0), .flush_cnt(fc0)
  );

  pipe_hazard_unit #(
    .REG_AW(4), .DEPTH(3), .REDIRECT_STG(1), .ZERO_REG(1), .CNT_W(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid),
    .id_srcA(id_srcA), .id_useA(id_useA), .id_srcB(id_srcB), .id_useB(id_useB),
    .id_dst(id_dst), .id_wen(id_wen), .id_load(id_load), .redirect(redirect),
    .stall_f(sf[1]), .stall_d(sd[1]), .bubble_e(be[1]), .flush_d(fd[1]),
    .fwdA_sel(fa[1]), .fwdB_sel(fb[1]), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  typedef struct {
    int sf, sd, be, fd, fa, fb, sc, fc;
  } obs_t;

  obs_t     exp_q [$];
  obs_t     last [2];
  int       n_cmp = 0;
  int       n_bad = 0;
  int       cyc_no = 0;

  // Reference state: index 0 models u0 (ZERO_REG=0, CNT_W=16), index 1 models u1 (ZERO_REG=1, CNT_W=2).
  bit       mv [2][3];
  bit [3:0] md [2][3];
  bit       ml [2][3];
  int       msc [2];
  int       mfc [2];

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int mfind(input int k, input logic u, input logic [3:0] s);
    if (!u) return 0;
    if (k == 1 && s == 4'd0) return 0;
    for (int i = 0; i < 3; i++) begin
      if (mv[k][i] && md[k][i] == s) return i + 1;
    end
    return 0;
  endfunction

  function automatic obs_t observe(input int k);
    obs_t o;
    o.sf = int'(sf[k]); o.sd = int'(sd[k]); o.be = int'(be[k]); o.fd = int'(fd[k]);
    o.fa = int'(fa[k]); o.fb = int'(fb[k]);
    o.sc = (k == 0) ? int'(sc0) : int'(sc1);
    o.fc = (k == 0) ? int'(fc0) : int'(fc1);
    return o;
  endfunction

  task automatic cmp_obs(input int k, input obs_t o, input obs_t e);
    string p;
    p = $sformatf("c%0d.u%0d.", cyc_no, k);
    check_eq({p, "stall_f"},   o.sf, e.sf);
    check_eq({p, "stall_d"},   o.sd, e.sd);
    check_eq({p, "bubble_e"},  o.be, e.be);
    check_eq({p, "flush_d"},   o.fd, e.fd);
    check_eq({p, "fwdA_sel"},  o.fa, e.fa);
    check_eq({p, "fwdB_sel"},  o.fb, e.fb);
    check_eq({p, "stall_cnt"}, o.sc, e.sc);
    check_eq({p, "flush_cnt"}, o.fc, e.fc);
  endtask

  task automatic model_step(input int k, input bit lu);
    int cmax;
    cmax = (k == 0) ? 65535 : 3;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) mv[k][i] = 1'b0;
      msc[k] = 0;
      mfc[k] = 0;
    end else if (!hold) begin
      if (lu && !redirect && msc[k] < cmax) msc[k]++;
      if (redirect && mfc[k] < cmax) mfc[k]++;
      mv[k][2] = mv[k][1];             md[k][2] = md[k][1]; ml[k][2] = ml[k][1];
      mv[k][1] = mv[k][0] && !redirect; md[k][1] = md[k][0]; ml[k][1] = ml[k][0];
      mv[k][0] = id_valid && id_wen && !lu && !redirect;
      md[k][0] = id_dst;
      ml[k][0] = id_load;
    end
  endtask

  task automatic cyc(input logic v, input logic ua, input logic [3:0] a,
                     input logic ub, input logic [3:0] b,
                     input logic wen, input logic ld, input logic [3:0] d,
                     input logic rd, input logic hd, input logic rn);
    obs_t e;
    obs_t o;
    bit   lu_m [2];
    @(negedge clk);
    id_valid = v;  id_useA = ua; id_srcA = a; id_useB = ub; id_srcB = b;
    id_wen = wen;  id_load = ld; id_dst = d;  redirect = rd; hold = hd; rst_n = rn;
    #1;
    for (int k = 0; k < 2; k++) begin
      e.fa = mfind(k, ua, a);
      e.fb = mfind(k, ub, b);
      lu_m[k] = v && ml[k][0] && (e.fa == 1 || e.fb == 1);
      e.sf = int'(lu_m[k] && !rd);
      e.sd = e.sf;
      e.be = int'(lu_m[k] || rd);
      e.fd = int'(rd);
      e.sc = msc[k];
      e.fc = mfc[k];
      exp_q.push_back(e);
    end
    for (int k = 0; k < 2; k++) begin
      o = observe(k);
      e = exp_q.pop_front();
      cmp_obs(k, o, e);
      last[k] = o;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, lu_m[k]);
    cyc_no++;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; id_valid = 1'b0; id_useA = 1'b0; id_useB = 1'b0;
    id_wen = 1'b0; id_load = 1'b0; redirect = 1'b0;
    id_srcA = '0; id_srcB = '0; id_dst = '0;
    repeat (2) @(posedge clk);

    // Reset state
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("rst_stall_f", last[0].sf, 0);
    check_eq("rst_stall_cnt", last[0].sc, 0);

    // ALU write r3, then two readers of r3
    cyc(1, 0, 0, 0, 0, 1, 0, 3, 0, 0, 1);
    cyc(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("t1_fwdA_ex", last[0].fa, 1);
    cyc(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("t1_fwdA_mem", last[0].fa, 2);
    check_eq("t1_nostall", last[0].sf, 0);

    // Load r5, dependent add stalls once then forwards from memory
    cyc(1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 1);
    cyc(1, 0, 0, 1, 5, 1, 0, 8, 0, 0, 1);
    check_eq("t2_stall_f", last[0].sf, 1);
    check_eq("t2_bubble_e", last[0].be, 1);
    cyc(1, 0, 0, 1, 5, 1, 0, 8, 0, 0, 1);
    check_eq("t2_fwdB_mem", last[0].fb, 2);
    check_eq("t2_stall_cnt", last[0].sc, 1);
    check_eq("t2_nostall", last[0].sf, 0);

    // Load-use coinciding with redirect
    cyc(1, 0, 0, 0, 0, 1, 0, 6, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 1);
    cyc(1, 1, 5, 0, 0, 1, 0, 9, 1, 0, 1);
    check_eq("t3_flush_d", last[0].fd, 1);
    check_eq("t3_stall_f", last[0].sf, 0);
    cyc(1, 1, 6, 1, 5, 0, 0, 0, 0, 0, 1);
    check_eq("t3_fwdA_kept", last[0].fa, 3);
    check_eq("t3_fwdB_cleared", last[0].fb, 0);
    check_eq("t3_flush_cnt", last[0].fc, 1);
    check_eq("t3_stall_cnt", last[0].sc, 1);

    // r0 as destination with and without hardwired zero
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("t4_zero_off", last[0].fa, 1);
    check_eq("t4_zero_on", last[1].fa, 0);

    // r2 at entries 0 and 2, then freeze for three cycles
    cyc(1, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1, 0, 7, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1);
    for (int n = 0; n < 3; n++) begin
      cyc(1, 1, 2, 0, 0, 1, 0, 11, 0, 1, 1);
      check_eq("t5_hold_fwdA", last[0].fa, 1);
    end
    cyc(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("t5_resume_fwdA", last[0].fa, 1);
    cyc(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("t5_advanced_fwdA", last[0].fa, 2);

    // Five load-use stalls saturate the narrow counter
    for (int n = 0; n < 5; n++) begin
      cyc(1, 0, 0, 0, 0, 1, 1, 4, 0, 0, 1);
      cyc(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("t6_sat_cnt2", last[1].sc, 3);
    check_eq("t6_cnt16", last[0].sc, 6);

    // Reset in the middle of a stall
    cyc(1, 0, 0, 0, 0, 1, 1, 4, 0, 0, 1);
    cyc(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t7_stall_before_rst", last[0].sf, 1);
    cyc(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("t7_stall_after_rst", last[0].sf, 0);
    check_eq("t7_cnt_after_rst", last[1].sc, 0);
    check_eq("t7_fwd_after_rst", last[0].fa, 0);

    // Random traffic over a small register range to force collisions
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 3) != 0,
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 60) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
